// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state type and operand helpers for the multiply/divide unit.
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_e;

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_divstep.sv
// One restoring-division step: shift the next dividend bit into the partial
// remainder, subtract the divisor if it fits, and emit the quotient bit.
module muldiv_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] partial;
  logic [WIDTH:0] diff;

  assign partial = {rem_i, bit_i};
  assign diff    = partial - {1'b0, divisor_i};
  // A borrow out of the top bit means the divisor did not fit.
  assign q_bit_o = ~diff[WIDTH];
  assign rem_o   = q_bit_o ? diff[WIDTH-1:0] : partial[WIDTH-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers (IDLE -> RUN x WIDTH -> FIX).
// Divider datapath is built only when MULDIV_DIV_EN is defined; otherwise div/divu raise err.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic               div0_q, div0_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step_mul, step_div, prod;
  logic [WIDTH-1:0]   quot, rem, res_hi, res_lo;

  assign accept = start && !cancel && (state_q == IDLE);
  assign a_neg  = op_is_signed(op) & a[WIDTH-1];
  assign b_neg  = op_is_signed(op) & b[WIDTH-1];
  assign a_mag  = a_neg ? -a : a;
  assign b_mag  = b_neg ? -b : b;

  // acc holds {partial product, remaining multiplier bits}; one multiplier bit per cycle.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign step_mul = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
  logic [WIDTH-1:0] div_rem;
  logic             div_qbit;

  // For division acc holds {remainder, dividend bits shifting out / quotient shifting in}.
  muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .rem_i     (acc_q[2*WIDTH-1:WIDTH]),
    .bit_i     (acc_q[WIDTH-1]),
    .divisor_i (opnd_q),
    .rem_o     (div_rem),
    .q_bit_o   (div_qbit)
  );
  assign step_div = {div_rem, acc_q[WIDTH-2:0], div_qbit};
`else
  localparam bit DIV_EN = 1'b0;
  assign step_div = acc_q;
`endif

  assign prod = neg_q  ? -acc_q : acc_q;
  assign quot = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem  = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  // A zero divisor leaves the dividend in the remainder, so only LO needs forcing.
  assign res_hi = is_div_q ? rem : prod[2*WIDTH-1:WIDTH];
  assign res_lo = is_div_q ? (div0_q ? '1 : quot) : prod[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    div0_d   = div0_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              state_d  = RUN;
              cnt_d    = '0;
              acc_d    = {{WIDTH{1'b0}}, b_mag};
              opnd_d   = a_mag;
              is_div_d = 1'b0;
              neg_d    = a_neg ^ b_neg;
            end
            OP_DIV, OP_DIVU: begin
              if (DIV_EN) begin
                state_d  = RUN;
                cnt_d    = '0;
                acc_d    = {{WIDTH{1'b0}}, a_mag};
                opnd_d   = b_mag;
                is_div_d = 1'b1;
                neg_d    = a_neg ^ b_neg;
                rneg_d   = a_neg;
                div0_d   = (b == '0);
              end else begin
                err_d = 1'b1;
              end
            end
            OP_MTHI: hi_d  = a;
            OP_MTLO: lo_d  = a;
            default: err_d = 1'b1;
          endcase
        end
      end
      RUN: begin
        if (cancel) begin
          state_d = IDLE;
        end else begin
          acc_d = is_div_q ? step_div : step_mul;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!cancel) begin
          hi_d   = res_hi;
          lo_d   = res_lo;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      div0_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      div0_q   <= div0_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign err  = err_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32) against an arithmetic reference model.
// Division checks are enabled when MULDIV_DIV_EN is defined; otherwise div ops must raise err.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset, start, cancel;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, err;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_hi = 32'h0;
  logic [31:0] exp_lo = 32'h0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .cancel (cancel),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  // Returns {hi, lo} as the architecture defines them.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint      sp;
    logic [63:0] ux, uy;
    int          q, r;
    case (o)
      3'b000: begin
        sp = longint'($signed(x)) * longint'($signed(y));
        return sp;
      end
      3'b001: begin
        ux = {32'd0, x};
        uy = {32'd0, y};
        return ux * uy;
      end
      3'b010: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = $signed(x) / $signed(y);
        r = $signed(x) % $signed(y);
        return {r, q};
      end
      3'b011: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bc);
    cyc = 0;
    bc  = 0;
    while (done !== 1'b1 && cyc < 60) begin
      if (busy === 1'b1) bc++;
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic run_arith(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input string tag);
    logic [63:0] r;
    int          cyc, bc;
    r = ref_model(o, x, y);
    issue(o, x, y);
    wait_done(cyc, bc);
    chk({tag, "_latency"}, 64'(cyc), 64'd33);
    chk({tag, "_busycycles"}, 64'(bc), 64'd33);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd0);
    chk({tag, "_err"}, 64'(err), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(r[63:32]));
    chk({tag, "_lo"}, 64'(lo), 64'(r[31:0]));
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h cycles=%0d", tag, o, x, y, hi, lo, cyc);
  endtask

  task automatic err_op(input logic [2:0] o, input string tag);
    issue(o, $urandom, $urandom);
    chk({tag, "_err"}, 64'(err), 64'd1);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_hi"}, 64'(hi), 64'(exp_hi));
    chk({tag, "_lo"}, 64'(lo), 64'(exp_lo));
    @(negedge clk);
    chk({tag, "_err_pulse"}, 64'(err), 64'd0);
    $display("%s op=%0d -> err pulse, hi=%h lo=%h", tag, o, hi, lo);
  endtask

  initial begin
    logic [63:0] r;
    logic [31:0] x, y;
    logic [2:0]  o;
    int          cyc, bc;
    bit          saw_done;

    reset  = 1'b1;
    start  = 1'b0;
    cancel = 1'b0;
    op     = 3'b000;
    a      = 32'd0;
    b      = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    $display("reset -> busy=%b hi=%h lo=%h", busy, hi, lo);

    run_arith(3'b000, 32'hFFFF_FFFD, 32'd7, "mult_neg");
    chk("mult_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
    chk("mult_neg_lo_const", 64'(lo), 64'hFFFF_FFEB);
    run_arith(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    chk("multu_max_hi_const", 64'(hi), 64'hFFFF_FFFE);
    chk("multu_max_lo_const", 64'(lo), 64'h0000_0001);

    for (int i = 0; i < 8; i++) begin
      o = 3'($urandom_range(0, 1));
      x = (i % 3 == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      y = (i == 5) ? 32'h8000_0000 : $urandom;
      run_arith(o, x, y, "mul_rand");
    end

`ifdef MULDIV_DIV_EN
    run_arith(3'b010, 32'hFFFF_FFF9, 32'd2, "div_neg");
    chk("div_neg_lo_const", 64'(lo), 64'hFFFF_FFFD);
    chk("div_neg_hi_const", 64'(hi), 64'hFFFF_FFFF);
    run_arith(3'b011, 32'd7, 32'd0, "divu_zero");
    chk("divu_zero_hi_const", 64'(hi), 64'd7);
    chk("divu_zero_lo_const", 64'(lo), 64'hFFFF_FFFF);
    run_arith(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    chk("div_ovf_lo_const", 64'(lo), 64'h8000_0000);
    chk("div_ovf_hi_const", 64'(hi), 64'd0);
    run_arith(3'b010, 32'hFFFF_FFF0, 32'd0, "div_zero_signed");
    for (int i = 0; i < 10; i++) begin
      o = 3'($urandom_range(2, 3));
      x = $urandom;
      y = (i % 4 == 0) ? 32'($urandom_range(0, 9)) : ((i % 4 == 1) ? (x >> $urandom_range(0, 31)) : $urandom);
      run_arith(o, x, y, "div_rand");
    end
`else
    err_op(3'b010, "div_disabled");
    err_op(3'b011, "divu_disabled");
`endif

    issue(3'b100, 32'h0000_1234, 32'd0);
    chk("mthi_hi", 64'(hi), 64'h1234);
    chk("mthi_busy", 64'(busy), 64'd0);
    chk("mthi_done", 64'(done), 64'd0);
    chk("mthi_lo_kept", 64'(lo), 64'(exp_lo));
    exp_hi = 32'h0000_1234;
    $display("mthi a=00001234 -> hi=%h", hi);
    x = $urandom;
    issue(3'b101, x, 32'd0);
    chk("mtlo_lo", 64'(lo), 64'(x));
    chk("mtlo_hi_kept", 64'(hi), 64'(exp_hi));
    exp_lo = x;
    $display("mtlo a=%h -> lo=%h", x, lo);

    err_op(3'b111, "reserved_111");
    err_op(3'b110, "reserved_110");

    // Second start while busy must be dropped, not queued.
    r = ref_model(3'b001, 32'h9ABC_DEF1, 32'h1357_9BDF);
    issue(3'b001, 32'h9ABC_DEF1, 32'h1357_9BDF);
    repeat (4) @(negedge clk);
    issue(3'b100, 32'h0000_5555, 32'd0);
    wait_done(cyc, bc);
    chk("busy_ignore_latency", 64'(cyc), 64'd28);
    chk("busy_ignore_hi", 64'(hi), 64'(r[63:32]));
    chk("busy_ignore_lo", 64'(lo), 64'(r[31:0]));
    exp_hi = r[63:32];
    exp_lo = r[31:0];
    @(negedge clk);
    chk("busy_ignore_no_queue", 64'(busy), 64'd0);
    $display("busy_ignore -> hi=%h lo=%h", hi, lo);

    issue(3'b000, 32'h0000_0003, 32'h0000_0005);
    repeat (9) @(negedge clk);
    chk("cancel_busy_before", 64'(busy), 64'd1);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel_busy_after", 64'(busy), 64'd0);
    saw_done = 1'b0;
    repeat (40) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("cancel_no_done", 64'(saw_done), 64'd0);
    chk("cancel_hi_kept", 64'(hi), 64'(exp_hi));
    chk("cancel_lo_kept", 64'(lo), 64'(exp_lo));
    $display("cancel -> busy=%b hi=%h lo=%h", busy, hi, lo);

    cancel = 1'b1;
    issue(3'b100, 32'hDEAD_BEEF, 32'd0);
    cancel = 1'b0;
    chk("cancel_start_hi", 64'(hi), 64'(exp_hi));
    chk("cancel_start_busy", 64'(busy), 64'd0);
    $display("cancel+start mthi -> hi=%h", hi);

    issue(3'b000, 32'h0001_0001, 32'h0000_FFFF);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    saw_done = 1'b0;
    repeat (40) begin
      if (done === 1'b1) saw_done = 1'b1;
      @(negedge clk);
    end
    chk("midrst_no_done", 64'(saw_done), 64'd0);
    $display("reset mid-op -> busy=%b hi=%h lo=%h", busy, hi, lo);

    run_arith(3'b000, 32'h7FFF_FFFF, 32'h8000_0000, "mult_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
